seg7_pattern_decoder: RTL and testbench
=======================================

Name: seg7_pattern_decoder

Overview:
- Receives an active-low 7-segment pattern bus (bit 6 = segment g … bit 0 = segment a) and recovers the 4-bit hex value it represents.
- Filters glitches by requiring the pattern to be stable before accepting it.
- Flags blank and illegal patterns, and counts accepted display changes.
- Sits on the display side of the dice design, for self-check and readback of the segment drivers.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; legal range 1..255.
- CNT_W, 8, width of the change counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- seg_in  in  7  active-low segment pattern {g,f,e,d,c,b,a}
- sample_en  in  1  1 = sample and advance; 0 = freeze all state and outputs
- digit  out  4  last accepted hex value
- valid  out  1  accepted pattern is one of the 16 hex glyphs
- blank  out  1  accepted pattern is 7'b1111111
- invalid  out  1  accepted pattern is none of the 17 legal patterns
- change_pulse  out  1  one-cycle pulse when a new, different pattern is accepted
- change_count  out  CNT_W  number of accepted changes, saturating

Behaviour:
- Decode table, pattern to value:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=b
  - 1000110=C, 0100001=d, 0000110=E, 0001110=F
  - 1111111 = blank; anything else = invalid.
- Reset values:
  - state IDLE; sample register 7'b1111111; stability counter 0; locked pattern 7'b1111111.
  - digit 0, valid 0, blank 0, invalid 0, change_pulse 0, change_count 0.
- Sampling: on each edge with sample_en=1, seg_in loads the sample register.
  - If the new sample equals the previous sample, the stability counter increments, saturating at STABLE_CYCLES.
  - Otherwise the stability counter loads 1.
- Acceptance: when the stability counter reaches STABLE_CYCLES, the sampled pattern is accepted.
- Latency: seg_in held constant from before edge E0 gives outputs updated at edge E0+STABLE_CYCLES-1. With STABLE_CYCLES=1, outputs update at E0.
- FSM:
  - IDLE: no pattern accepted since reset; outputs at reset values. Goes to LOCKED on acceptance.
  - LOCKED: outputs reflect the locked pattern. Goes to SETTLE when the sample differs from the locked pattern.
  - SETTLE: outputs hold the previous locked values. Goes to LOCKED on acceptance of any pattern.
- Outputs on acceptance:
  - valid, blank and invalid are mutually exclusive; exactly one is 1.
  - digit updates only for hex glyphs and holds its prior value on blank or invalid.
- Change tracking:
  - change_pulse=1 for exactly one cycle when the accepted pattern differs from the locked pattern, or on the first acceptance after reset.
  - Re-accepting the same pattern after a glitch produces no pulse and no count.
  - change_count increments by 1 with each pulse and saturates at 2^CNT_W-1.
- Glitches: any pattern held fewer than STABLE_CYCLES samples is never accepted and leaves outputs unchanged.
- sample_en=0:
  - Sample register, counter, state, digit and flags all hold.
  - change_pulse is forced to 0.
  - Resuming continues the stability count from where it stopped.
- Reset mid-SETTLE: returns to IDLE with reset values; pending pattern discarded.
- rst has priority over sample_en.

Test Plan:
- Reset, then seg_in=1111111 constant, STABLE_CYCLES=4 -> at edge E0+3: blank=1, valid=0, digit=0, change_pulse=1 for one cycle, change_count=1.
- Lock 0100100 (2), then drive 0110000 for 2 cycles and return to 0100100 -> digit stays 2, valid=1, no extra pulse, change_count unchanged.
- Locked on 2, drive 0101010 for 4 cycles -> invalid=1, valid=0, digit holds 2, one pulse; then drive 0001110 -> digit=F, valid=1, second pulse.
- Step all 16 glyphs, each held 4 cycles -> digit = 0..F in order, valid=1 throughout, 16 pulses; with CNT_W=2, change_count saturates at 3.
- Mid-settle (2 of 4 samples of 1111001), drop sample_en for 5 cycles, then restore -> outputs frozen while low; digit=1 accepted after 2 further edges.
- Assert rst during SETTLE -> next cycle: all outputs at reset values; the next accepted pattern pulses change_pulse and sets change_count=1.

Source files
------------

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder
// Recovers the hex value shown on an active-low 7-segment bus {g,f,e,d,c,b,a}.
// A pattern must be sampled STABLE_CYCLES times in a row before it is accepted.
// Blank and illegal patterns are flagged, and accepted display changes are counted.
// sample_en=0 freezes every register; only change_pulse is forced low.

module seg7_pattern_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             sample_en,
  output logic [3:0]       digit,
  output logic             valid,
  output logic             blank,
  output logic             invalid,
  output logic             change_pulse,
  output logic [CNT_W-1:0] change_count
);

  localparam logic [6:0]       PAT_BLANK  = 7'b1111111;
  localparam logic [7:0]       STABLE_TGT = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  // Glyph lookup: bit 4 says "is a hex glyph", bits 3:0 carry its value.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1000000: res = {1'b1, 4'h0};
      7'b1111001: res = {1'b1, 4'h1};
      7'b0100100: res = {1'b1, 4'h2};
      7'b0110000: res = {1'b1, 4'h3};
      7'b0011001: res = {1'b1, 4'h4};
      7'b0010010: res = {1'b1, 4'h5};
      7'b0000010: res = {1'b1, 4'h6};
      7'b1111000: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0010000: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b0000011: res = {1'b1, 4'hB};
      7'b1000110: res = {1'b1, 4'hC};
      7'b0100001: res = {1'b1, 4'hD};
      7'b0000110: res = {1'b1, 4'hE};
      7'b0001110: res = {1'b1, 4'hF};
      default:    res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  // Registers and their next-state values
  state_e           state_q,   state_d;
  logic [6:0]       sample_q,  sample_d;
  logic [7:0]       stab_q,    stab_d;
  logic [6:0]       locked_q,  locked_d;
  logic [3:0]       digit_q,   digit_d;
  logic             valid_q,   valid_d;
  logic             blank_q,   blank_d;
  logic             invalid_q, invalid_d;
  logic             pulse_q,   pulse_d;
  logic [CNT_W-1:0] count_q,   count_d;

  logic             accept_s;
  logic             new_pattern_s;
  logic [4:0]       glyph_s;

  assign glyph_s = decode_glyph(seg_in);

  // Sample register and stability counter; acceptance is judged on the post-edge count
  always_comb begin
    sample_d = sample_q;
    stab_d   = stab_q;
    accept_s = 1'b0;
    if (sample_en) begin
      sample_d = seg_in;
      if (seg_in == sample_q) begin
        if (stab_q < STABLE_TGT) begin
          stab_d = stab_q + 8'd1;
        end else begin
          stab_d = stab_q;
        end
      end else begin
        stab_d = 8'd1;
      end
      accept_s = (stab_d == STABLE_TGT);
    end else begin
      accept_s = 1'b0;
    end
  end

  // FSM next state: IDLE until first acceptance, SETTLE while a new pattern is pending
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (sample_en && !accept_s && (seg_in != locked_q)) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_SETTLE: begin
        if (accept_s) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output datapath: classify the accepted pattern and track display changes
  always_comb begin
    locked_d      = locked_q;
    digit_d       = digit_q;
    valid_d       = valid_q;
    blank_d       = blank_q;
    invalid_d     = invalid_q;
    pulse_d       = 1'b0;
    count_d       = count_q;
    new_pattern_s = (state_q == ST_IDLE) || (seg_in != locked_q);
    if (accept_s) begin
      locked_d = seg_in;
      if (glyph_s[4]) begin
        digit_d   = glyph_s[3:0];
        valid_d   = 1'b1;
        blank_d   = 1'b0;
        invalid_d = 1'b0;
      end else if (seg_in == PAT_BLANK) begin
        valid_d   = 1'b0;
        blank_d   = 1'b1;
        invalid_d = 1'b0;
      end else begin
        valid_d   = 1'b0;
        blank_d   = 1'b0;
        invalid_d = 1'b1;
      end
      // Re-accepting the locked pattern after a glitch is not a change
      if (new_pattern_s) begin
        pulse_d = 1'b1;
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_ONE;
        end else begin
          count_d = count_q;
        end
      end else begin
        pulse_d = 1'b0;
      end
    end else begin
      pulse_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sample_q  <= PAT_BLANK;
      stab_q    <= 8'd0;
      locked_q  <= PAT_BLANK;
      digit_q   <= 4'h0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b0;
      invalid_q <= 1'b0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      stab_q    <= stab_d;
      locked_q  <= locked_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      invalid_q <= invalid_d;
      pulse_q   <= pulse_d;
      count_q   <= count_d;
    end
  end

  assign digit        = digit_q;
  assign valid        = valid_q;
  assign blank        = blank_q;
  assign invalid      = invalid_q;
  assign change_pulse = pulse_q;
  assign change_count = count_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Bench for seg7_pattern_decoder: directed scenarios plus randomized traffic
// checked against a history-based reference model.

module tb_seg7_pattern_decoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       sample_en;

  logic [3:0] digit, digit2;
  logic       valid, blank, invalid, change_pulse;
  logic       valid2, blank2, invalid2, change_pulse2;
  logic [7:0] change_count;
  logic [1:0] change_count2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] glyph_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  seg7_pattern_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sample_en(sample_en),
    .digit(digit), .valid(valid), .blank(blank), .invalid(invalid),
    .change_pulse(change_pulse), .change_count(change_count));

  seg7_pattern_decoder #(.STABLE_CYCLES(S), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sample_en(sample_en),
    .digit(digit2), .valid(valid2), .blank(blank2), .invalid(invalid2),
    .change_pulse(change_pulse2), .change_count(change_count2));

  // Reference model: a pattern is accepted when the last S enabled samples are identical
  logic [6:0] hist [$];
  bit         m_has;
  logic [6:0] m_locked;
  logic [3:0] m_digit;
  bit         m_valid, m_blank, m_invalid, m_pulse;
  int         m_pulses;

  function automatic int glyph_index(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph_tbl[i] == p) return i;
    return -1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge(input logic r, input logic [6:0] s, input logic en);
    bit stable;
    int idx;
    if (r) begin
      hist.delete();
      m_has = 0; m_locked = 7'h7f; m_digit = 4'h0;
      m_valid = 0; m_blank = 0; m_invalid = 0; m_pulse = 0; m_pulses = 0;
    end else if (!en) begin
      m_pulse = 0;
    end else begin
      hist.push_back(s);
      if (hist.size() > S) void'(hist.pop_front());
      stable = (hist.size() == S);
      foreach (hist[k]) if (hist[k] != s) stable = 0;
      m_pulse = 0;
      if (stable) begin
        if (!m_has || s != m_locked) begin
          m_pulse = 1;
          m_pulses++;
        end
        m_has = 1;
        m_locked = s;
        idx = glyph_index(s);
        if (idx >= 0) begin
          m_digit = idx[3:0]; m_valid = 1; m_blank = 0; m_invalid = 0;
        end else if (s == 7'h7f) begin
          m_valid = 0; m_blank = 1; m_invalid = 0;
        end else begin
          m_valid = 0; m_blank = 0; m_invalid = 1;
        end
      end
    end
  endtask

  // Drive one clock edge and advance the model; outputs are sampled 1 time unit after the edge
  task automatic cycle(input logic r, input logic [6:0] s, input logic en);
    rst = r; seg_in = s; sample_en = en;
    @(posedge clk);
    model_edge(r, s, en);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 7'b0100100, 1'b1);
    n_checks++; if (digit !== 4'h0) begin n_fail++; $display("FAIL reset_digit: got %h want 0", digit); end
    n_checks++; if ({valid, blank, invalid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {valid, blank, invalid}); end
    n_checks++; if (change_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", change_pulse); end
    n_checks++; if (change_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", change_count); end
    n_checks++; if (change_count2 !== 2'd0) begin n_fail++; $display("FAIL reset_count2: got %0d want 0", change_count2); end
  endtask

  task automatic test_blank_first();
    for (int i = 0; i < S; i++) begin
      cycle(1'b0, 7'b1111111, 1'b1);
      if (i < S - 1) begin
        n_checks++; if ({change_pulse, blank} !== 2'b00) begin n_fail++; $display("FAIL blank_early: edge %0d pulse/blank %b want 00", i, {change_pulse, blank}); end
      end
    end
    n_checks++; if ({valid, blank, invalid} !== 3'b010) begin n_fail++; $display("FAIL blank_flags: got %b want 010", {valid, blank, invalid}); end
    n_checks++; if (digit !== 4'h0) begin n_fail++; $display("FAIL blank_digit: got %h want 0", digit); end
    n_checks++; if (change_pulse !== 1'b1) begin n_fail++; $display("FAIL blank_pulse: got %b want 1", change_pulse); end
    n_checks++; if (change_count !== 8'd1) begin n_fail++; $display("FAIL blank_count: got %0d want 1", change_count); end
    cycle(1'b0, 7'b1111111, 1'b1);
    n_checks++; if (change_pulse !== 1'b0) begin n_fail++; $display("FAIL blank_pulse_once: got %b want 0", change_pulse); end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < S; i++) cycle(1'b0, 7'b0100100, 1'b1);
    n_checks++; if ({digit, valid, change_pulse} !== {4'h2, 1'b1, 1'b1}) begin n_fail++; $display("FAIL lock2: digit/valid/pulse %h/%b/%b want 2/1/1", digit, valid, change_pulse); end
    n_checks++; if (change_count !== 8'd2) begin n_fail++; $display("FAIL lock2_count: got %0d want 2", change_count); end
    cycle(1'b0, 7'b0110000, 1'b1);
    cycle(1'b0, 7'b0110000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 7'b0100100, 1'b1);
      n_checks++; if ({digit, valid, change_pulse} !== {4'h2, 1'b1, 1'b0}) begin n_fail++; $display("FAIL glitch_hold: edge %0d digit/valid/pulse %h/%b/%b want 2/1/0", i, digit, valid, change_pulse); end
      n_checks++; if (change_count !== 8'd2) begin n_fail++; $display("FAIL glitch_count: got %0d want 2", change_count); end
    end
  endtask

  task automatic test_invalid();
    for (int i = 0; i < S; i++) cycle(1'b0, 7'b0101010, 1'b1);
    n_checks++; if ({valid, blank, invalid} !== 3'b001) begin n_fail++; $display("FAIL inv_flags: got %b want 001", {valid, blank, invalid}); end
    n_checks++; if (digit !== 4'h2) begin n_fail++; $display("FAIL inv_digit: got %h want 2", digit); end
    n_checks++; if ({change_pulse, change_count} !== {1'b1, 8'd3}) begin n_fail++; $display("FAIL inv_change: pulse %b count %0d want 1 3", change_pulse, change_count); end
    for (int i = 0; i < S; i++) cycle(1'b0, 7'b0001110, 1'b1);
    n_checks++; if ({digit, valid, invalid} !== {4'hF, 1'b1, 1'b0}) begin n_fail++; $display("FAIL f_accept: digit/valid/invalid %h/%b/%b want F/1/0", digit, valid, invalid); end
    n_checks++; if ({change_pulse, change_count} !== {1'b1, 8'd4}) begin n_fail++; $display("FAIL f_change: pulse %b count %0d want 1 4", change_pulse, change_count); end
  endtask

  task automatic test_all_glyphs();
    cycle(1'b1, 7'b1111111, 1'b1);
    for (int g = 0; g < 16; g++) begin
      for (int c = 0; c < S; c++) begin
        cycle(1'b0, glyph_tbl[g], 1'b1);
        if (c < S - 1 && g > 0) begin
          n_checks++; if ({digit, valid, change_pulse} !== {4'(g - 1), 1'b1, 1'b0}) begin n_fail++; $display("FAIL glyph_settle: g %0d digit/valid/pulse %h/%b/%b", g, digit, valid, change_pulse); end
        end
      end
      n_checks++; if ({digit, valid, change_pulse} !== {4'(g), 1'b1, 1'b1}) begin n_fail++; $display("FAIL glyph_accept: g %0d digit/valid/pulse %h/%b/%b want %h/1/1", g, digit, valid, change_pulse, 4'(g)); end
      n_checks++; if (change_count !== 8'(g + 1)) begin n_fail++; $display("FAIL glyph_count: got %0d want %0d", change_count, g + 1); end
      n_checks++; if (change_count2 !== 2'(sat(g + 1, 3))) begin n_fail++; $display("FAIL glyph_count_sat: got %0d want %0d", change_count2, sat(g + 1, 3)); end
    end
  endtask

  task automatic test_freeze();
    cycle(1'b0, 7'b1111001, 1'b1);
    cycle(1'b0, 7'b1111001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 7'($urandom), 1'b0);
      n_checks++; if ({digit, valid, change_pulse} !== {4'hF, 1'b1, 1'b0}) begin n_fail++; $display("FAIL freeze_hold: edge %0d digit/valid/pulse %h/%b/%b want F/1/0", i, digit, valid, change_pulse); end
      n_checks++; if (change_count !== 8'd16) begin n_fail++; $display("FAIL freeze_count: got %0d want 16", change_count); end
    end
    cycle(1'b0, 7'b1111001, 1'b1);
    n_checks++; if ({digit, change_pulse} !== {4'hF, 1'b0}) begin n_fail++; $display("FAIL resume_early: digit/pulse %h/%b want F/0", digit, change_pulse); end
    cycle(1'b0, 7'b1111001, 1'b1);
    n_checks++; if ({digit, valid, change_pulse} !== {4'h1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL resume_accept: digit/valid/pulse %h/%b/%b want 1/1/1", digit, valid, change_pulse); end
    n_checks++; if ({change_count, change_count2} !== {8'd17, 2'd3}) begin n_fail++; $display("FAIL resume_count: got %0d/%0d want 17/3", change_count, change_count2); end
  endtask

  task automatic test_reset_settle();
    cycle(1'b0, 7'b0100100, 1'b1);
    cycle(1'b0, 7'b0100100, 1'b1);
    cycle(1'b1, 7'b0100100, 1'b1);
    n_checks++; if ({digit, valid, blank, invalid, change_pulse} !== 8'h00) begin n_fail++; $display("FAIL rst_settle_outs: got %h want 00", {digit, valid, blank, invalid, change_pulse}); end
    n_checks++; if (change_count !== 8'd0) begin n_fail++; $display("FAIL rst_settle_count: got %0d want 0", change_count); end
    for (int i = 0; i < S; i++) begin
      cycle(1'b0, 7'b1111001, 1'b1);
      if (i < S - 1) begin
        n_checks++; if ({valid, change_pulse} !== 2'b00) begin n_fail++; $display("FAIL rst_settle_early: edge %0d valid/pulse %b want 00", i, {valid, change_pulse}); end
      end
    end
    n_checks++; if ({digit, valid, change_pulse} !== {4'h1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL rst_settle_accept: digit/valid/pulse %h/%b/%b want 1/1/1", digit, valid, change_pulse); end
    n_checks++; if ({change_count, change_count2} !== {8'd1, 2'd1}) begin n_fail++; $display("FAIL rst_settle_count1: got %0d/%0d want 1/1", change_count, change_count2); end
  endtask

  task automatic test_random();
    logic [6:0] pat;
    int         sel, len;
    logic       en, r;
    cycle(1'b1, 7'b1111111, 1'b1);
    for (int seg = 0; seg < 200; seg++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      pat = glyph_tbl[$urandom_range(0, 15)];
      else if (sel == 7) pat = 7'b1111111;
      else               pat = 7'($urandom);
      len = $urandom_range(1, 6);
      for (int c = 0; c < len; c++) begin
        en = ($urandom_range(0, 9) != 0);
        r  = ($urandom_range(0, 199) == 0);
        cycle(r, pat, en);
        n_checks++; if (digit !== m_digit) begin n_fail++; $display("FAIL rnd_digit: got %h want %h", digit, m_digit); end
        n_checks++; if ({valid, blank, invalid} !== {m_valid, m_blank, m_invalid}) begin n_fail++; $display("FAIL rnd_flags: got %b want %b", {valid, blank, invalid}, {m_valid, m_blank, m_invalid}); end
        n_checks++; if (change_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse: got %b want %b", change_pulse, m_pulse); end
        n_checks++; if (change_count !== 8'(sat(m_pulses, 255))) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", change_count, sat(m_pulses, 255)); end
        n_checks++; if (change_count2 !== 2'(sat(m_pulses, 3))) begin n_fail++; $display("FAIL rnd_count2: got %0d want %0d", change_count2, sat(m_pulses, 3)); end
        n_checks++; if ({digit2, valid2, blank2, invalid2, change_pulse2} !== {m_digit, m_valid, m_blank, m_invalid, m_pulse}) begin n_fail++; $display("FAIL rnd_dut2: got %h want %h", {digit2, valid2, blank2, invalid2, change_pulse2}, {m_digit, m_valid, m_blank, m_invalid, m_pulse}); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; seg_in = 7'b1111111; sample_en = 1'b0;
    test_reset();
    test_blank_first();
    test_glitch();
    test_invalid();
    test_all_glyphs();
    test_freeze();
    test_reset_settle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
